blood_sample_sequencer: RTL and testbench
=========================================

Name: blood_sample_sequencer

Overview:
Drives the blood abnormality detector as a sequenced stream.
- Accepts one pH/type sample per valid/ready handshake.
- Holds the sample on the detector's bloodPH/bloodType inputs for a programmable settle window.
- Captures the detector's bloodAbnormality verdict and returns it on a result handshake.
- Keeps running sample/abnormal statistics and raises a consecutive-abnormal alarm.
- Sits between the sample source (sensor front end or bench stimulus) and the combinational detector.

Parameters:
SETTLE_CYCLES, 2, cycles the sample is held before the verdict is sampled; legal range 1..15.
COUNT_W, 8, width of the saturating statistics counters.
ALARM_THRESH, 3, number of consecutive abnormal verdicts that asserts alarm; legal range 1..(2^COUNT_W-1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
sampleValid  input  1  source has a sample on sampleBloodPH/sampleBloodType.
sampleReady  output  1  sequencer can accept a sample.
sampleBloodPH  input  4  incoming pH code.
sampleBloodType  input  3  incoming blood type code.
bloodPH  output  4  registered pH driven to the detector.
bloodType  output  3  registered type driven to the detector.
bloodAbnormality  input  1  detector verdict, combinational from bloodPH/bloodType.
resultValid  output  1  verdict available.
resultReady  input  1  consumer takes the verdict.
resultAbnormal  output  1  captured verdict.
resultPH  output  4  pH code the verdict belongs to.
resultType  output  3  type code the verdict belongs to.
clrStats  input  1  synchronous single-cycle clear of the statistics and alarm.
sampleCount  output  COUNT_W  verdicts captured, saturating.
abnormalCount  output  COUNT_W  abnormal verdicts captured, saturating.
alarm  output  1  consecutive-abnormal run has reached ALARM_THRESH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - bloodPH=0, bloodType=0, resultValid=0, resultAbnormal=0, resultPH=0, resultType=0.
  - sampleCount=0, abnormalCount=0, run counter=0, alarm=0.
  - sampleReady=1 once rst_n deasserts.
- State machine IDLE -> SETTLE -> REPORT -> IDLE.
- IDLE:
  - sampleReady=1 (combinational from state).
  - On sampleValid&&sampleReady: register sampleBloodPH/sampleBloodType into bloodPH/bloodType, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - sampleReady=0; bloodPH/bloodType held stable.
  - Counter decrements each cycle.
  - On the edge where the counter is 0:
    - resultAbnormal<=bloodAbnormality, resultPH<=bloodPH, resultType<=bloodType.
    - Update the statistics; resultValid<=1; go to REPORT.
- Latency: accept at edge k gives resultValid high after edge k+SETTLE_CYCLES.
- REPORT:
  - Result outputs held stable while resultValid=1 and resultReady=0.
  - On resultReady: resultValid<=0, go to IDLE.
  - There is no same-cycle re-accept: sampleReady rises the cycle after the result is taken, giving at most one sample per SETTLE_CYCLES+2 cycles.
- bloodPH/bloodType keep the last sample after REPORT; they change only on acceptance.
- Statistics, updated on the capture edge:
  - sampleCount increments, saturating at 2^COUNT_W-1.
  - If the verdict is abnormal: abnormalCount increments (saturating) and the run counter increments (saturating).
  - Otherwise the run counter clears to 0.
  - alarm is registered: alarm=1 while run counter >= ALARM_THRESH; it clears when a normal verdict resets the run.
- clrStats:
  - Zeroes sampleCount, abnormalCount, run counter and alarm on the next edge.
  - If it coincides with a capture edge, clear wins and that verdict is not counted.
  - The verdict itself is still reported normally.
- Sample inputs while not in IDLE are ignored; the source must hold sampleValid and data until handshake.
- Reset mid-operation: a sample in flight and any pending result are discarded; resultValid drops immediately (asynchronous).

Test Plan:
1. Reset, then sampleValid with pH=4'h7, type=3'h2, stub bloodAbnormality=0, SETTLE_CYCLES=2 -> bloodPH=7/bloodType=2 after accept edge; resultValid after exactly 2 more edges with resultAbnormal=0, resultPH=7, resultType=2; sampleCount=1, abnormalCount=0.
2. resultReady held low 5 cycles -> resultValid, resultAbnormal, resultPH and resultType stable; sampleReady=0; a new sampleValid is not accepted until 1 cycle after resultReady.
3. Three consecutive samples with stub abnormality=1, then one with 0, ALARM_THRESH=3 -> alarm rises on the third capture edge; abnormalCount=3; alarm falls on the fourth capture; sampleCount=4.
4. COUNT_W=3, 9 abnormal samples -> sampleCount and abnormalCount stick at 7 with no wrap.
5. clrStats asserted on an abnormal capture edge after 2 prior abnormals -> all counts 0, alarm 0; resultAbnormal=1 still reported.
6. rst_n pulsed low during SETTLE and again during REPORT -> all outputs zero immediately; sampleReady=1 after release; the next sample completes normally.

Source files
------------

// File: rtl/blood_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : blood_sample_sequencer
// Brief    : Feeds pH/type samples to a combinational abnormality detector,
//            captures each verdict after a settle window, keeps statistics.
// Revision : 1.0
// ============================================================================
module blood_sample_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 8,
    parameter int ALARM_THRESH  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sampleValid,
    output logic               sampleReady,
    input  logic [3:0]         sampleBloodPH,
    input  logic [2:0]         sampleBloodType,
    output logic [3:0]         bloodPH,
    output logic [2:0]         bloodType,
    input  logic               bloodAbnormality,
    output logic               resultValid,
    input  logic               resultReady,
    output logic               resultAbnormal,
    output logic [3:0]         resultPH,
    output logic [2:0]         resultType,
    input  logic               clrStats,
    output logic [COUNT_W-1:0] sampleCount,
    output logic [COUNT_W-1:0] abnormalCount,
    output logic               alarm
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [3:0]         c_settle_load = 4'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] c_count_max   = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] c_thresh      = COUNT_W'(ALARM_THRESH);
    localparam logic [COUNT_W-1:0] c_one         = COUNT_W'(1);

    state_t             state_q, state_d;
    logic [3:0]         settle_q, settle_d;
    logic [3:0]         ph_q, ph_d;
    logic [2:0]         type_q, type_d;
    logic               res_valid_q, res_valid_d;
    logic               res_abn_q, res_abn_d;
    logic [3:0]         res_ph_q, res_ph_d;
    logic [2:0]         res_type_q, res_type_d;
    logic [COUNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [COUNT_W-1:0] abn_cnt_q, abn_cnt_d;
    logic [COUNT_W-1:0] run_q, run_d;
    logic               alarm_q, alarm_d;
    logic               w_capture;

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        ph_d         = ph_q;
        type_d       = type_q;
        res_valid_d  = res_valid_q;
        res_abn_d    = res_abn_q;
        res_ph_d     = res_ph_q;
        res_type_d   = res_type_q;
        sample_cnt_d = sample_cnt_q;
        abn_cnt_d    = abn_cnt_q;
        run_d        = run_q;
        w_capture    = (state_q == S_SETTLE) && (settle_q == 4'd0);

        case (state_q)
            S_IDLE: begin
                if (sampleValid) begin
                    ph_d     = sampleBloodPH;
                    type_d   = sampleBloodType;
                    settle_d = c_settle_load;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == 4'd0) begin
                    res_abn_d   = bloodAbnormality;
                    res_ph_d    = ph_q;
                    res_type_d  = type_q;
                    res_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_REPORT: begin
                if (resultReady) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_capture) begin
            sample_cnt_d = (sample_cnt_q == c_count_max) ? sample_cnt_q : sample_cnt_q + c_one;
            if (bloodAbnormality) begin
                abn_cnt_d = (abn_cnt_q == c_count_max) ? abn_cnt_q : abn_cnt_q + c_one;
                run_d     = (run_q == c_count_max) ? run_q : run_q + c_one;
            end else begin
                run_d = '0;
            end
        end

        // A clear on the capture edge drops that verdict from the statistics.
        if (clrStats) begin
            sample_cnt_d = '0;
            abn_cnt_d    = '0;
            run_d        = '0;
        end

        alarm_d = (run_d >= c_thresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            settle_q     <= 4'd0;
            ph_q         <= 4'd0;
            type_q       <= 3'd0;
            res_valid_q  <= 1'b0;
            res_abn_q    <= 1'b0;
            res_ph_q     <= 4'd0;
            res_type_q   <= 3'd0;
            sample_cnt_q <= '0;
            abn_cnt_q    <= '0;
            run_q        <= '0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            ph_q         <= ph_d;
            type_q       <= type_d;
            res_valid_q  <= res_valid_d;
            res_abn_q    <= res_abn_d;
            res_ph_q     <= res_ph_d;
            res_type_q   <= res_type_d;
            sample_cnt_q <= sample_cnt_d;
            abn_cnt_q    <= abn_cnt_d;
            run_q        <= run_d;
            alarm_q      <= alarm_d;
        end
    end

    assign sampleReady    = (state_q == S_IDLE);
    assign bloodPH        = ph_q;
    assign bloodType      = type_q;
    assign resultValid    = res_valid_q;
    assign resultAbnormal = res_abn_q;
    assign resultPH       = res_ph_q;
    assign resultType     = res_type_q;
    assign sampleCount    = sample_cnt_q;
    assign abnormalCount  = abn_cnt_q;
    assign alarm          = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_blood_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_blood_sample_sequencer
// Brief    : Self-checking bench for blood_sample_sequencer with a stub detector.
// Revision : 1.0
// ============================================================================
module tb_blood_sample_sequencer;
    localparam int SETTLE = 2;
    localparam int CW     = 3;
    localparam int MAXC   = 7;
    localparam int THRESH = 3;

    logic          clk;
    logic          rst_n;
    logic          sampleValid;
    logic          sampleReady;
    logic [3:0]    sampleBloodPH;
    logic [2:0]    sampleBloodType;
    logic [3:0]    bloodPH;
    logic [2:0]    bloodType;
    logic          bloodAbnormality;
    logic          resultValid;
    logic          resultReady;
    logic          resultAbnormal;
    logic [3:0]    resultPH;
    logic [2:0]    resultType;
    logic          clrStats;
    logic [CW-1:0] sampleCount;
    logic [CW-1:0] abnormalCount;
    logic          alarm;

    blood_sample_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .COUNT_W      (CW),
        .ALARM_THRESH (THRESH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sampleValid     (sampleValid),
        .sampleReady     (sampleReady),
        .sampleBloodPH   (sampleBloodPH),
        .sampleBloodType (sampleBloodType),
        .bloodPH         (bloodPH),
        .bloodType       (bloodType),
        .bloodAbnormality(bloodAbnormality),
        .resultValid     (resultValid),
        .resultReady     (resultReady),
        .resultAbnormal  (resultAbnormal),
        .resultPH        (resultPH),
        .resultType      (resultType),
        .clrStats        (clrStats),
        .sampleCount     (sampleCount),
        .abnormalCount   (abnormalCount),
        .alarm           (alarm)
    );

    // Stub detector: pH codes outside 6..9 are abnormal.
    assign bloodAbnormality = (bloodPH < 4'd6) || (bloodPH > 4'd9);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ph;
        logic [2:0] ty;
        logic       abn;
        int         hold;
        logic       clr;
    } vec_t;

    typedef struct {
        logic [3:0] ph;
        logic [2:0] ty;
        logic       abn;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;
    int   m_sc   = 0;
    int   m_ac   = 0;
    int   m_run  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic do_sample(input vec_t v);
        exp_t e;
        bit   acc;
        bit   ready_now;
        int   lat;
        sampleBloodPH   = v.ph;
        sampleBloodType = v.ty;
        sampleValid     = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            ready_now = sampleReady;
            @(posedge clk); #1;
            acc = ready_now;
        end
        sampleValid = 1'b0;
        if (!acc) begin
            fail_now("accept_timeout");
            return;
        end
        e.ph = v.ph; e.ty = v.ty; e.abn = v.abn;
        sbq.push_back(e);
        check("bloodPH_after_accept", bloodPH, v.ph);
        check("bloodType_after_accept", bloodType, v.ty);
        check("sampleReady_busy", sampleReady, 0);

        lat = 0;
        while (!resultValid && lat < 40) begin
            if (v.clr && lat == SETTLE - 1) clrStats = 1'b1;
            @(posedge clk); #1;
            clrStats = 1'b0;
            lat++;
        end
        if (!resultValid) begin
            fail_now("result_timeout");
            return;
        end
        check("latency", lat, SETTLE);
        if (sbq.size() == 0) begin
            fail_now("scoreboard_empty");
            return;
        end
        e = sbq.pop_front();
        check("resultAbnormal", resultAbnormal, e.abn);
        check("resultPH", resultPH, e.ph);
        check("resultType", resultType, e.ty);

        if (v.clr) begin
            m_sc = 0; m_ac = 0; m_run = 0;
        end else begin
            m_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
            if (e.abn) begin
                m_ac  = (m_ac < MAXC) ? m_ac + 1 : MAXC;
                m_run = (m_run < MAXC) ? m_run + 1 : MAXC;
            end else begin
                m_run = 0;
            end
        end
        check("sampleCount", sampleCount, m_sc);
        check("abnormalCount", abnormalCount, m_ac);
        check("alarm", alarm, (m_run >= THRESH) ? 1 : 0);

        // Offer a competing sample while the result is parked.
        sampleValid     = 1'b1;
        sampleBloodPH   = ~v.ph;
        sampleBloodType = ~v.ty;
        repeat (v.hold) begin
            @(posedge clk); #1;
            check("hold_resultValid", resultValid, 1);
            check("hold_resultAbnormal", resultAbnormal, e.abn);
            check("hold_resultPH", resultPH, e.ph);
            check("hold_resultType", resultType, e.ty);
            check("hold_sampleReady", sampleReady, 0);
            check("hold_bloodPH", bloodPH, v.ph);
        end
        resultReady = 1'b1;
        @(posedge clk); #1;
        resultReady = 1'b0;
        check("take_resultValid", resultValid, 0);
        check("take_sampleReady", sampleReady, 1);
        check("take_no_reaccept", bloodPH, v.ph);
        sampleValid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'h7, 3'h2, 1'b0, 5, 1'b0};
        vecs[1]  = '{4'h3, 3'h1, 1'b1, 0, 1'b0};
        vecs[2]  = '{4'hC, 3'h5, 1'b1, 1, 1'b0};
        vecs[3]  = '{4'h1, 3'h0, 1'b1, 0, 1'b0};
        vecs[4]  = '{4'h8, 3'h3, 1'b0, 2, 1'b0};
        vecs[5]  = '{4'h2, 3'h4, 1'b1, 0, 1'b0};
        vecs[6]  = '{4'hA, 3'h6, 1'b1, 0, 1'b0};
        vecs[7]  = '{4'hF, 3'h7, 1'b1, 0, 1'b0};
        vecs[8]  = '{4'h0, 3'h1, 1'b1, 0, 1'b0};
        vecs[9]  = '{4'h5, 3'h2, 1'b1, 0, 1'b0};
        vecs[10] = '{4'hB, 3'h3, 1'b1, 0, 1'b0};
        vecs[11] = '{4'h9, 3'h0, 1'b0, 0, 1'b0};
        vecs[12] = '{4'h4, 3'h4, 1'b1, 0, 1'b0};
        vecs[13] = '{4'hD, 3'h5, 1'b1, 0, 1'b0};
        vecs[14] = '{4'h2, 3'h6, 1'b1, 1, 1'b1};
        vecs[15] = '{4'h6, 3'h1, 1'b0, 0, 1'b0};

        rst_n = 1'b1;
        sampleValid = 1'b0;
        sampleBloodPH = 4'h0;
        sampleBloodType = 3'h0;
        resultReady = 1'b0;
        clrStats = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_sampleReady", sampleReady, 1);
        check("rst_bloodPH", bloodPH, 0);
        check("rst_bloodType", bloodType, 0);
        check("rst_resultValid", resultValid, 0);
        check("rst_resultAbnormal", resultAbnormal, 0);
        check("rst_resultPH", resultPH, 0);
        check("rst_resultType", resultType, 0);
        check("rst_sampleCount", sampleCount, 0);
        check("rst_abnormalCount", abnormalCount, 0);
        check("rst_alarm", alarm, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) do_sample(vecs[i]);

        // Reset while settling.
        sampleBloodPH = 4'h9; sampleBloodType = 3'h4; sampleValid = 1'b1;
        @(posedge clk); #1;
        sampleValid = 1'b0;
        check("settle_bloodPH", bloodPH, 4'h9);
        check("settle_sampleCount", sampleCount, 1);
        rst_n = 1'b0; #1;
        check("rstS_bloodPH", bloodPH, 0);
        check("rstS_bloodType", bloodType, 0);
        check("rstS_resultValid", resultValid, 0);
        check("rstS_resultPH", resultPH, 0);
        check("rstS_sampleCount", sampleCount, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        check("rstS_sampleReady", sampleReady, 1);
        m_sc = 0; m_ac = 0; m_run = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rstS_no_result", resultValid, 0);

        // Reset while a result is pending.
        sampleBloodPH = 4'h3; sampleBloodType = 3'h3; sampleValid = 1'b1;
        @(posedge clk); #1;
        sampleValid = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        check("report_resultValid", resultValid, 1);
        check("report_resultAbnormal", resultAbnormal, 1);
        check("report_sampleCount", sampleCount, 1);
        rst_n = 1'b0; #1;
        check("rstR_resultValid", resultValid, 0);
        check("rstR_resultAbnormal", resultAbnormal, 0);
        check("rstR_resultPH", resultPH, 0);
        check("rstR_sampleCount", sampleCount, 0);
        check("rstR_abnormalCount", abnormalCount, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        check("rstR_sampleReady", sampleReady, 1);
        do_sample('{4'hA, 3'h5, 1'b1, 1, 1'b0});
        check("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
